// File: rtl/chroma_upsampler.sv
// chroma_upsampler: reads 2:1 horizontally decimated chroma rows (two 8-bit
// samples per word), rebuilds full-rate chroma with a 6-tap symmetric
// interpolation FIR and writes one output word (even, odd sample) per cycle.
// A six-sample window c[k-2..k+3] slides one sample per output; the sample
// entering the window is taken straight from R_data (high byte) or from a
// holding register (low byte), so reads run one word ahead of the window.
module chroma_upsampler #(
  parameter int ROW_PIX = 320,
  parameter int ROWS    = 240,
  parameter int AW      = 18,
  parameter int RD_BASE = 0,
  parameter int WR_BASE = 'h10000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          start,
  output logic [AW-1:0] Raddr,
  input  logic [15:0]   R_data,
  output logic [AW-1:0] Waddr,
  output logic [15:0]   W_data,
  output logic          Wrenb,
  output logic          done
);

  localparam int L   = ROW_PIX / 2;   // decimated samples per row
  localparam int WPR = ROW_PIX / 4;   // input words per row
  localparam int KW  = $clog2(ROW_PIX);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_RUN, S_DRAIN, S_ROW_END, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [AW-1:0] raddr_reg, waddr_reg, wr_off;
  logic [15:0]   wdata_reg, hold_reg;
  logic          wrenb_reg;
  logic [KW-1:0] rd_word, k_cnt;
  logic [RW-1:0] row_cnt;
  logic [1:0]    prime_cnt;
  logic [7:0]    win [0:5];

  logic signed [19:0] s05, s14, s23, acc, shr;
  logic [7:0]         filt, in_sample;

  assign Raddr  = raddr_reg;
  assign Waddr  = waddr_reg;
  assign W_data = wdata_reg;
  assign Wrenb  = wrenb_reg;

  // FSM state register; clear behaves like reset on the next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state_reg <= S_IDLE;
    else if (clear) state_reg <= S_IDLE;
    else            state_reg <= state_next;
  end

  // FSM next-state: three priming cycles, then one output per cycle per row
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start) state_next = S_PRIME;
      S_PRIME:   if (prime_cnt == 2'd2) state_next = S_RUN;
      S_RUN:     if (k_cnt == KW'(L - 5)) state_next = S_DRAIN;
      S_DRAIN:   if (k_cnt == KW'(L - 1)) state_next = S_ROW_END;
      S_ROW_END: state_next = (row_cnt == RW'(ROWS - 1)) ? S_DONE : S_PRIME;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // FSM outputs: done follows the cycle holding the final write
  always_comb begin
    done = 1'b0;
    if (state_reg == S_DONE) done = 1'b1;
  end

  // FIR on the current window plus selection of the sample entering it;
  // once c[k+4] would pass the row end the last sample is replicated
  always_comb begin
    s05 = $signed({12'd0, win[0]}) + $signed({12'd0, win[5]});
    s14 = $signed({12'd0, win[1]}) + $signed({12'd0, win[4]});
    s23 = $signed({12'd0, win[2]}) + $signed({12'd0, win[3]});
    acc = 20'sd21 * s05 - 20'sd52 * s14 + 20'sd159 * s23 + 20'sd128;
    shr = acc >>> 8;
    if (shr < 20'sd0)        filt = 8'd0;
    else if (shr > 20'sd255) filt = 8'hff;
    else                     filt = shr[7:0];
    if (state_reg == S_RUN) in_sample = k_cnt[0] ? hold_reg[7:0] : R_data[15:8];
    else                    in_sample = win[5];
  end

  // Datapath: read addressing, window shifting and registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr_reg <= '0; waddr_reg <= '0; wdata_reg <= '0; wrenb_reg <= 1'b0;
      wr_off    <= '0; hold_reg  <= '0; rd_word   <= '0; k_cnt     <= '0;
      row_cnt   <= '0; prime_cnt <= '0;
      for (int i = 0; i < 6; i++) win[i] <= '0;
    end else if (clear) begin
      raddr_reg <= '0; waddr_reg <= '0; wdata_reg <= '0; wrenb_reg <= 1'b0;
      wr_off    <= '0; hold_reg  <= '0; rd_word   <= '0; k_cnt     <= '0;
      row_cnt   <= '0; prime_cnt <= '0;
      for (int i = 0; i < 6; i++) win[i] <= '0;
    end else begin
      wrenb_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            raddr_reg <= AW'(RD_BASE);
            row_cnt   <= '0;
            wr_off    <= '0;
          end
        end
        S_PRIME: begin
          prime_cnt <= prime_cnt + 2'd1;
          if (prime_cnt == 2'd0) begin
            raddr_reg <= raddr_reg + AW'(1);
          end else if (prime_cnt == 2'd1) begin
            // word 0 arrives; word 2 is requested so it lands during k=0
            hold_reg  <= R_data;
            raddr_reg <= raddr_reg + AW'(1);
            rd_word   <= KW'(2);
          end else begin
            // word 1 arrives: window {c0,c0,c0,c1,c2,c3}
            win[0]    <= hold_reg[15:8];
            win[1]    <= hold_reg[15:8];
            win[2]    <= hold_reg[15:8];
            win[3]    <= hold_reg[7:0];
            win[4]    <= R_data[15:8];
            win[5]    <= R_data[7:0];
            prime_cnt <= '0;
            k_cnt     <= '0;
          end
        end
        S_RUN, S_DRAIN: begin
          wrenb_reg <= 1'b1;
          waddr_reg <= AW'(WR_BASE) + wr_off;
          wdata_reg <= {win[2], filt};
          wr_off    <= wr_off + AW'(1);
          for (int i = 0; i < 5; i++) win[i] <= win[i + 1];
          win[5]    <= in_sample;
          k_cnt     <= k_cnt + KW'(1);
          // even k consumes a fresh word's high byte; keep its low byte
          // and move the read pointer on, never past the row's last word
          if (!k_cnt[0]) begin
            hold_reg <= R_data;
            if (rd_word != KW'(WPR - 1)) begin
              rd_word   <= rd_word + KW'(1);
              raddr_reg <= raddr_reg + AW'(1);
            end
          end
        end
        S_ROW_END: begin
          // rows are contiguous in memory, so the next row starts one past
          if (row_cnt != RW'(ROWS - 1)) begin
            row_cnt   <= row_cnt + RW'(1);
            raddr_reg <= raddr_reg + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chroma_upsampler.sv
// Directed bench for chroma_upsampler with N=16 (L=8, 4 input words per
// row) and two rows per frame. Expected output words are hand-computed
// from the interpolation formula with edge replication.
module tb_chroma_upsampler;

  localparam int AW  = 18;
  localparam int WRB = 'h10000;

  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, start = 1'b0;
  logic [AW-1:0] Raddr, Waddr;
  logic [15:0]   R_data, W_data;
  logic          Wrenb, done;

  logic [15:0]   mem [0:7];
  logic [AW-1:0] cap_addr [$];
  logic [15:0]   cap_data [$];
  int            cap_cyc  [$];
  int            cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  logic          rd_oob = 1'b0;
  int            vectors = 0, miscompares = 0;
  logic [15:0]   exp_w [16];

  chroma_upsampler #(
    .ROW_PIX(16), .ROWS(2), .AW(AW), .RD_BASE(0), .WR_BASE(WRB)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start),
    .Raddr(Raddr), .R_data(R_data), .Waddr(Waddr), .W_data(W_data),
    .Wrenb(Wrenb), .done(done)
  );

  always #5 clk = ~clk;

  // synchronous-read memory model and cycle counter
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    R_data <= mem[Raddr[2:0]];
  end

  // observe outputs mid-cycle
  always @(negedge clk) begin
    if (Wrenb) begin
      cap_addr.push_back(Waddr);
      cap_data.push_back(W_data);
      cap_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (Raddr > AW'(7)) rd_oob <= 1'b1;
  end

  task automatic load_mem(input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
    mem[0] = a0; mem[1] = a1; mem[2] = a2; mem[3] = a3;
    mem[4] = b0; mem[5] = b1; mem[6] = b2; mem[7] = b3;
  endtask

  task automatic set_ramp_exp();
    exp_w = '{16'h0007, 16'h1019, 16'h2028, 16'h3038,
              16'h4048, 16'h5057, 16'h6069, 16'h7071,
              16'h8080, 16'h8080, 16'h8080, 16'h8080,
              16'h8080, 16'h8080, 16'h8080, 16'h8080};
  endtask

  // pulses start, optionally pulses it again 'extra' cycles later, waits for done
  task automatic run_frame(input int extra, output int base, output int d0);
    int cnt;
    base = cap_data.size();
    d0   = done_cnt;
    @(negedge clk); #1;
    start = 1'b1; start_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while (done_cnt == d0 && cnt < 200) begin
      start = (cnt == extra);
      @(negedge clk); #1;
      cnt++;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    vectors += 5;
    if (Wrenb !== 1'b0)  begin miscompares++; $display("FAIL reset_wrenb: got %b want 0", Wrenb); end
    if (done !== 1'b0)   begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    if (Raddr !== '0)    begin miscompares++; $display("FAIL reset_raddr: got %h want 0", Raddr); end
    if (Waddr !== '0)    begin miscompares++; $display("FAIL reset_waddr: got %h want 0", Waddr); end
    if (W_data !== '0)   begin miscompares++; $display("FAIL reset_wdata: got %h want 0", W_data); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors += 2;
    if (Wrenb !== 1'b0) begin miscompares++; $display("FAIL idle_wrenb: got %b want 0", Wrenb); end
    if (done !== 1'b0)  begin miscompares++; $display("FAIL idle_done: got %b want 0", done); end
    $display("reset: outputs checked");
  endtask

  task automatic test_flat();
    int base, d0, last;
    load_mem(16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'h8080);
    for (int i = 0; i < 16; i++) exp_w[i] = 16'h8080;
    run_frame(-1, base, d0);
    vectors++;
    if (cap_data.size() - base != 16) begin
      miscompares++; $display("FAIL flat_count: got %0d writes want 16", cap_data.size() - base);
    end
    for (int i = 0; i < 16 && base + i < cap_data.size(); i++) begin
      vectors++;
      if (cap_data[base+i] !== exp_w[i] || cap_addr[base+i] !== AW'(WRB + i)) begin
        miscompares++;
        $display("FAIL flat_w%0d: got %h/%h want %h/%h", i, cap_addr[base+i], cap_data[base+i], AW'(WRB + i), exp_w[i]);
      end else $display("flat w%0d addr=%h data=%h ok", i, cap_addr[base+i], cap_data[base+i]);
      if (i > 0) begin
        vectors++;
        if ((i != 8 && cap_cyc[base+i] != cap_cyc[base+i-1] + 1) ||
            (i == 8 && cap_cyc[base+i] > cap_cyc[base+i-1] + 9)) begin
          miscompares++;
          $display("FAIL flat_gap%0d: got cycle %0d after %0d", i, cap_cyc[base+i], cap_cyc[base+i-1]);
        end
      end
    end
    if (cap_data.size() > base) begin
      vectors++;
      if (cap_cyc[base] > start_cyc + 9) begin
        miscompares++; $display("FAIL flat_latency: got first write cycle %0d want <= %0d", cap_cyc[base], start_cyc + 9);
      end
    end
    last = (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] : -100;
    vectors++;
    if (done_cnt - d0 != 1 || done_cyc != last + 1) begin
      miscompares++; $display("FAIL flat_done: got %0d pulses at %0d want 1 at %0d", done_cnt - d0, done_cyc, last + 1);
    end
  endtask

  task automatic test_ramp();
    int base, d0, last;
    load_mem(16'h0010, 16'h2030, 16'h4050, 16'h6070, 16'h8080, 16'h8080, 16'h8080, 16'h8080);
    set_ramp_exp();
    run_frame(-1, base, d0);
    vectors++;
    if (cap_data.size() - base != 16) begin
      miscompares++; $display("FAIL ramp_count: got %0d writes want 16", cap_data.size() - base);
    end
    for (int i = 0; i < 16 && base + i < cap_data.size(); i++) begin
      vectors++;
      if (cap_data[base+i] !== exp_w[i] || cap_addr[base+i] !== AW'(WRB + i)) begin
        miscompares++;
        $display("FAIL ramp_w%0d: got %h/%h want %h/%h", i, cap_addr[base+i], cap_data[base+i], AW'(WRB + i), exp_w[i]);
      end else $display("ramp w%0d addr=%h data=%h ok", i, cap_addr[base+i], cap_data[base+i]);
    end
    last = (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] : -100;
    vectors++;
    if (done_cnt - d0 != 1 || done_cyc != last + 1) begin
      miscompares++; $display("FAIL ramp_done: got %0d pulses at %0d want 1 at %0d", done_cnt - d0, done_cyc, last + 1);
    end
  endtask

  task automatic test_clip();
    int base, d0, last;
    load_mem(16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    exp_w = '{16'h0000, 16'h0015, 16'h0000, 16'h0080,
              16'hFFFF, 16'hFFEA, 16'hFFFF, 16'hFFFF,
              16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
              16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    run_frame(-1, base, d0);
    vectors++;
    if (cap_data.size() - base != 16) begin
      miscompares++; $display("FAIL clip_count: got %0d writes want 16", cap_data.size() - base);
    end
    for (int i = 0; i < 16 && base + i < cap_data.size(); i++) begin
      vectors++;
      if (cap_data[base+i] !== exp_w[i] || cap_addr[base+i] !== AW'(WRB + i)) begin
        miscompares++;
        $display("FAIL clip_w%0d: got %h/%h want %h/%h", i, cap_addr[base+i], cap_data[base+i], AW'(WRB + i), exp_w[i]);
      end else $display("clip w%0d addr=%h data=%h ok", i, cap_addr[base+i], cap_data[base+i]);
    end
    last = (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] : -100;
    vectors += 2;
    if (done_cnt - d0 != 1 || done_cyc != last + 1) begin
      miscompares++; $display("FAIL clip_done: got %0d pulses at %0d want 1 at %0d", done_cnt - d0, done_cyc, last + 1);
    end
    if (rd_oob !== 1'b0) begin
      miscompares++; $display("FAIL read_range: got read beyond word 7 (%b) want none", rd_oob);
    end
  endtask

  task automatic test_start_ignored();
    int base, d0, last;
    load_mem(16'h0010, 16'h2030, 16'h4050, 16'h6070, 16'h8080, 16'h8080, 16'h8080, 16'h8080);
    set_ramp_exp();
    run_frame(6, base, d0);
    repeat (30) @(negedge clk);
    #1;
    vectors++;
    if (cap_data.size() - base != 16) begin
      miscompares++; $display("FAIL restart_count: got %0d writes want 16", cap_data.size() - base);
    end
    for (int i = 0; i < 16 && base + i < cap_data.size(); i++) begin
      vectors++;
      if (cap_data[base+i] !== exp_w[i] || cap_addr[base+i] !== AW'(WRB + i)) begin
        miscompares++;
        $display("FAIL restart_w%0d: got %h/%h want %h/%h", i, cap_addr[base+i], cap_data[base+i], AW'(WRB + i), exp_w[i]);
      end else $display("restart w%0d addr=%h data=%h ok", i, cap_addr[base+i], cap_data[base+i]);
    end
    last = (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] : -100;
    vectors++;
    if (done_cnt - d0 != 1 || done_cyc != last + 1) begin
      miscompares++; $display("FAIL restart_done: got %0d pulses at %0d want 1 at %0d", done_cnt - d0, done_cyc, last + 1);
    end
  endtask

  task automatic test_async_rst();
    int base, d0, cnt, b2, last;
    load_mem(16'h0010, 16'h2030, 16'h4050, 16'h6070, 16'h8080, 16'h8080, 16'h8080, 16'h8080);
    set_ramp_exp();
    base = cap_data.size();
    @(negedge clk); #1; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    cnt = 0;
    while (cap_data.size() < base + 3 && cnt < 50) begin
      @(negedge clk); #1; cnt++;
    end
    #2 rst = 1'b1;
    #1;
    vectors += 5;
    if (Wrenb !== 1'b0) begin miscompares++; $display("FAIL arst_wrenb: got %b want 0", Wrenb); end
    if (done !== 1'b0)  begin miscompares++; $display("FAIL arst_done: got %b want 0", done); end
    if (Raddr !== '0)   begin miscompares++; $display("FAIL arst_raddr: got %h want 0", Raddr); end
    if (Waddr !== '0)   begin miscompares++; $display("FAIL arst_waddr: got %h want 0", Waddr); end
    if (W_data !== '0)  begin miscompares++; $display("FAIL arst_wdata: got %h want 0", W_data); end
    @(negedge clk); #1; rst = 1'b0;
    b2 = cap_data.size(); d0 = done_cnt;
    repeat (20) @(negedge clk);
    #1;
    vectors++;
    if (cap_data.size() != b2 || done_cnt != d0) begin
      miscompares++; $display("FAIL arst_quiet: got %0d writes %0d dones want 0 0", cap_data.size() - b2, done_cnt - d0);
    end
    $display("async reset: frame aborted");
    run_frame(-1, base, d0);
    vectors++;
    if (cap_data.size() - base != 16) begin
      miscompares++; $display("FAIL arst_count: got %0d writes want 16", cap_data.size() - base);
    end
    for (int i = 0; i < 16 && base + i < cap_data.size(); i++) begin
      vectors++;
      if (cap_data[base+i] !== exp_w[i] || cap_addr[base+i] !== AW'(WRB + i)) begin
        miscompares++;
        $display("FAIL arst_w%0d: got %h/%h want %h/%h", i, cap_addr[base+i], cap_data[base+i], AW'(WRB + i), exp_w[i]);
      end else $display("arst w%0d addr=%h data=%h ok", i, cap_addr[base+i], cap_data[base+i]);
    end
    last = (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] : -100;
    vectors++;
    if (done_cnt - d0 != 1 || done_cyc != last + 1) begin
      miscompares++; $display("FAIL arst_done2: got %0d pulses at %0d want 1 at %0d", done_cnt - d0, done_cyc, last + 1);
    end
  endtask

  task automatic test_clear_drain();
    int base, d0, cnt, last;
    load_mem(16'h0010, 16'h2030, 16'h4050, 16'h6070, 16'h8080, 16'h8080, 16'h8080, 16'h8080);
    set_ramp_exp();
    base = cap_data.size(); d0 = done_cnt;
    @(negedge clk); #1; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    cnt = 0;
    // the 5th write appears while k=5 is in the drain phase
    while (cap_data.size() < base + 5 && cnt < 50) begin
      @(negedge clk); #1; cnt++;
    end
    clear = 1'b1;
    @(negedge clk); #1;
    clear = 1'b0;
    vectors += 5;
    if (Wrenb !== 1'b0) begin miscompares++; $display("FAIL clr_wrenb: got %b want 0", Wrenb); end
    if (Raddr !== '0)   begin miscompares++; $display("FAIL clr_raddr: got %h want 0", Raddr); end
    if (Waddr !== '0)   begin miscompares++; $display("FAIL clr_waddr: got %h want 0", Waddr); end
    if (W_data !== '0)  begin miscompares++; $display("FAIL clr_wdata: got %h want 0", W_data); end
    if (cap_data.size() != base + 5) begin
      miscompares++; $display("FAIL clr_writes: got %0d writes want 5", cap_data.size() - base);
    end
    repeat (30) @(negedge clk);
    #1;
    vectors++;
    if (cap_data.size() != base + 5 || done_cnt != d0) begin
      miscompares++; $display("FAIL clr_quiet: got %0d writes %0d dones want 5 0", cap_data.size() - base, done_cnt - d0);
    end
    $display("clear: frame aborted");
    run_frame(-1, base, d0);
    vectors++;
    if (cap_data.size() - base != 16) begin
      miscompares++; $display("FAIL clr_count: got %0d writes want 16", cap_data.size() - base);
    end
    for (int i = 0; i < 16 && base + i < cap_data.size(); i++) begin
      vectors++;
      if (cap_data[base+i] !== exp_w[i] || cap_addr[base+i] !== AW'(WRB + i)) begin
        miscompares++;
        $display("FAIL clr_w%0d: got %h/%h want %h/%h", i, cap_addr[base+i], cap_data[base+i], AW'(WRB + i), exp_w[i]);
      end else $display("clr w%0d addr=%h data=%h ok", i, cap_addr[base+i], cap_data[base+i]);
    end
    last = (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] : -100;
    vectors++;
    if (done_cnt - d0 != 1 || done_cyc != last + 1) begin
      miscompares++; $display("FAIL clr_done: got %0d pulses at %0d want 1 at %0d", done_cnt - d0, done_cyc, last + 1);
    end
  endtask

  initial begin
    load_mem(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    test_reset();
    test_flat();
    test_ramp();
    test_clip();
    test_start_ignored();
    test_async_rst();
    test_clear_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
